// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_fs.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one bit pair per clock, LSB first, result a-b with
// unsigned borrow and signed overflow flags.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
  logic             borrow;
  logic             a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bout;
  logic             last_bit;

  fs u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_nx   = {cell_d, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status flags are flops that track the upcoming state, so they line up
  // with the state register without any input-to-output combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == SHIFT);
      done <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      d      <= '0;
      bo     <= 1'b0;
      ov     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nx;
          borrow <= cell_bout;
          cnt    <= cnt + CW'(1);
          // Final bit: publish the assembled difference directly from res_nx.
          if (last_bit) begin
            d  <= res_nx;
            bo <= cell_bout;
            ov <= (a_msb ^ b_msb) & (res_nx[WIDTH-1] ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomised checks of serial_sub at WIDTH=8 and WIDTH=16.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel16 = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        start8, start16;
  logic        busy8, done8, bo8, ov8;
  logic        busy16, done16, bo16, ov16;
  logic [7:0]  d8;
  logic [15:0] d16;

  logic        busy_o, done_o, bo_o, ov_o;
  logic [31:0] d_o;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [31:0] ah [0:63];
  logic [31:0] bh [0:63];

  always #5 clk = ~clk;

  assign start8  = start & ~sel16;
  assign start16 = start & sel16;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a_in[7:0]),
    .b     (b_in[7:0]),
    .busy  (busy8),
    .done  (done8),
    .d     (d8),
    .bo    (bo8),
    .ov    (ov8)
  );

  serial_sub #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a_in[15:0]),
    .b     (b_in[15:0]),
    .busy  (busy16),
    .done  (done16),
    .d     (d16),
    .bo    (bo16),
    .ov    (ov16)
  );

  always_comb begin
    busy_o = sel16 ? busy16 : busy8;
    done_o = sel16 ? done16 : done8;
    bo_o   = sel16 ? bo16   : bo8;
    ov_o   = sel16 ? ov16   : ov8;
    d_o    = sel16 ? {16'h0, d16} : {24'h0, d8};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_sub(input int unsigned w, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] ed, output logic ebo, output logic eov);
    longint mask, sa, sb, diff, lim;
    mask = (longint'(1) << w) - 1;
    ed   = 32'(((longint'(av) - longint'(bv)) & mask));
    ebo  = (av < bv);
    sa   = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
    sb   = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    diff = sa - sb;
    lim  = longint'(1) << (w - 1);
    eov  = (diff >= lim) || (diff < -lim);
  endfunction

  // One full operation: timing of busy/done plus result flags.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_d, input logic exp_bo, input logic exp_ov);
    int unsigned w, busy_n, done_n, done_at, both;
    w = sel16 ? 16 : 8;
    busy_n = 0; done_n = 0; done_at = 0; both = 0;
    @(negedge clk);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy_o) busy_n++;
    for (int unsigned k = 1; k <= w + 1; k++) begin
      a_in = $urandom;
      b_in = $urandom;
      @(posedge clk);
      #1;
      if (busy_o) busy_n++;
      if (done_o) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (busy_o && done_o) both++;
      if (k == w) begin
        check({tag, ".d"},  d_o, exp_d);
        check({tag, ".bo"}, 32'(bo_o), 32'(exp_bo));
        check({tag, ".ov"}, 32'(ov_o), 32'(exp_ov));
      end
    end
    check({tag, ".busy_cycles"}, busy_n, w);
    check({tag, ".done_edge"}, done_at, w);
    check({tag, ".done_pulses"}, done_n, 1);
    check({tag, ".busy_and_done"}, both, 0);
  endtask

  task automatic run_random(input int unsigned n);
    int unsigned w;
    logic [31:0] av, bv, ed, mask;
    logic ebo, eov;
    w = sel16 ? 16 : 8;
    mask = (32'h1 << w) - 32'h1;
    for (int unsigned i = 0; i < n; i++) begin
      av = $urandom & mask;
      bv = $urandom & mask;
      ref_sub(w, av, bv, ed, ebo, eov);
      run_op(sel16 ? "rnd16" : "rnd8", av, bv, ed, ebo, eov);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int unsigned w, period, spurious, done_seen;
    logic [31:0] ed;
    logic ebo, eov;

    #1;
    check("rst.busy", 32'(busy8), 0);
    check("rst.done", 32'(done8), 0);
    check("rst.d",    32'(d8), 0);
    check("rst.bo",   32'(bo8), 0);
    check("rst.ov",   32'(ov8), 0);
    #20;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // First operation starts on the first rising edge after reset release.
    run_op("sub_05_03", 32'h05, 32'h03, 32'h02, 1'b0, 1'b0);
    run_op("sub_03_05", 32'h03, 32'h05, 32'hFE, 1'b1, 1'b0);
    run_op("sub_80_01", 32'h80, 32'h01, 32'h7F, 1'b0, 1'b1);
    run_op("sub_7F_FF", 32'h7F, 32'hFF, 32'h80, 1'b1, 1'b1);

    // start held high with operands changing every cycle.
    w = 8;
    period = w + 2;
    spurious = 0;
    for (int unsigned e = 0; e < 3 * period; e++) begin
      @(negedge clk);
      a_in  = $urandom & 32'hFF;
      b_in  = $urandom & 32'hFF;
      start = 1'b1;
      ah[e] = a_in;
      bh[e] = b_in;
      @(posedge clk);
      #1;
      if ((e % period) == w) begin
        ref_sub(w, ah[e-w], bh[e-w], ed, ebo, eov);
        check("hold.done", 32'(done_o), 1);
        check("hold.d",    d_o, ed);
        check("hold.bo",   32'(bo_o), 32'(ebo));
        check("hold.ov",   32'(ov_o), 32'(eov));
      end else if (done_o) begin
        spurious++;
      end
    end
    start = 1'b0;
    check("hold.spurious_done", spurious, 0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    a_in  = 32'h05;
    b_in  = 32'h03;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(busy8), 0);
    check("midrst.done", 32'(done8), 0);
    check("midrst.d",    32'(d8), 0);
    check("midrst.bo",   32'(bo8), 0);
    check("midrst.ov",   32'(ov8), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int unsigned k = 0; k < w + 4; k++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) done_seen++;
    end
    check("midrst.no_done", done_seen, 0);
    run_op("sub_FF_FF", 32'hFF, 32'hFF, 32'h00, 1'b0, 1'b0);

    run_random(1000);

    sel16 = 1'b1;
    run_op("w16_8000_0001", 32'h8000, 32'h0001, 32'h7FFF, 1'b0, 1'b1);
    run_op("w16_0000_0001", 32'h0000, 32'h0001, 32'hFFFF, 1'b1, 1'b0);
    run_op("w16_1234_1234", 32'h1234, 32'h1234, 32'h0000, 1'b0, 1'b0);
    run_random(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 busy  output  1  high while the block is in SHIFT.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 d  output  WIDTH  difference a-b mod 2^WIDTH; holds until the next accepted start.
REQ-010 bo  output  1  final borrow out; 1 when unsigned a < b.
REQ-011 ov  output  1  signed (two's-complement) overflow of a-b.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; registered outputs only, no combinational input-to-output path.
REQ-013 IDLE: start=1 at edge N -> capture a, b into shift registers; clear borrow flop; clear bit counter; go to SHIFT.
REQ-014 IDLE with start=0 -> remain in IDLE; outputs hold.
REQ-015 SHIFT: each edge processes one bit pair, LSB first, through one full-subtractor cell using the borrow flop as borrow-in.
REQ-016 SHIFT: diff bit shifts into the result register from the MSB side; both operand registers shift right by one; borrow flop takes the cell's borrow-out.
REQ-017 SHIFT lasts exactly WIDTH edges (N+1..N+WIDTH); counter is ceil(log2(WIDTH+1)) bits wide and never wraps.
REQ-018 At edge N+WIDTH: load d from the result register and bo from the final borrow; set ov = (a[MSB]!=b[MSB]) & (d[MSB]!=a[MSB]) using the captured operands; go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-020 Latency: start accepted at edge N -> done high between edges N+WIDTH and N+WIDTH+1.
REQ-021 Throughput: next start can be accepted at edge N+WIDTH+2 at the earliest (one operation per WIDTH+2 cycles).
REQ-022 start high in SHIFT or DONE is ignored; no queuing; the in-flight operation is unaffected.
REQ-023 a, b changes after the accepting edge have no effect on the in-flight result.
REQ-024 busy = 1 in SHIFT only; busy and done are never high together.

Reset
REQ-025 rst_n low -> immediately: state IDLE, busy=0, done=0, d=0, bo=0, ov=0; borrow flop, counter and shift registers = 0.
REQ-026 Reset mid-SHIFT or in DONE aborts the operation; no done pulse is issued for it.
REQ-027 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package serial_sub_pkg holds the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 The per-bit cell is a separate sub-module fs (inputs a, b, bin; outputs d=a^b^bin, bout=(~a&b)|(~a&bin)|(b&bin)), instantiated once.
REQ-030 Unused state encoding 2'd3 -> next state IDLE, outputs unchanged.

Verification
REQ-031 WIDTH=8, a=0x05, b=0x03, start 1 cycle -> busy for 8 cycles, done at N+8, d=0x02, bo=0, ov=0.
REQ-032 a=0x03, b=0x05 -> d=0xFE, bo=1, ov=0.
REQ-033 a=0x80, b=0x01 -> d=0x7F, bo=0, ov=1; a=0x7F, b=0xFF -> d=0x80, bo=1, ov=1.
REQ-034 start held high throughout, with a/b changed every cycle during SHIFT -> exactly one done per WIDTH+2 cycles; each result matches the operands at its accepting edge.
REQ-035 rst_n pulsed low at SHIFT cycle 4 -> all outputs 0 asynchronously, no done; next start with a=0xFF, b=0xFF -> d=0x00, bo=0, ov=0.
REQ-036 Random regression over 1000 operand pairs, WIDTH=8 and WIDTH=16 -> d, bo, ov match a reference model; done spacing never below WIDTH+2 cycles.
